// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one 1-cycle synchronous ROM across 4 requesters.
// Grant is combinational in IDLE; beats trail ROM issue by one register stage with no backpressure.
module rom_burst_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req_valid,
    output logic [3:0]            req_ready,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*ADDR_W-1:0]   req_len,
    output logic                  rom_en,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_id,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_last,
    output logic                  busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;
    localparam logic [ADDR_W-1:0] ONE = 1;

    logic [0:0]        state;
    logic [1:0]        ptr;
    logic [1:0]        cur_id;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] cnt;
    logic              found;
    logic              grant;

    // First valid requester at or after ptr, wrapping modulo 4.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Reset gates the grant so req_ready drops without waiting for a clock edge.
    assign grant     = (state == IDLE) && found && !rst;
    assign req_ready = grant ? (4'b0001 << win) : 4'b0000;
    assign rom_en    = (state == BURST);
    assign rom_addr  = rom_en ? cur_addr : '0;
    assign rsp_data  = rom_data;
    assign busy      = rom_en | rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            cur_addr  <= '0;
            cnt       <= '0;
            cur_id    <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_id    <= 2'd0;
        end else begin
            rsp_valid <= rom_en;
            rsp_id    <= cur_id;
            rsp_last  <= rom_en && (cnt == '0);
            if (state == IDLE) begin
                if (grant) begin
                    cur_addr <= req_addr[win*ADDR_W +: ADDR_W];
                    cnt      <= req_len[win*ADDR_W +: ADDR_W];
                    cur_id   <= win;
                    ptr      <= win + 2'd1;
                    state    <= BURST;
                end
            end else begin
                cur_addr <= cur_addr + ONE;
                if (cnt != '0) begin
                    cnt <= cnt - ONE;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: behavioural ROM, request queues per requester, and a
// transaction-level reference model stepped once per cycle.
module tb_rom_burst_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [4*AW-1:0] req_addr;
    logic [4*AW-1:0] req_len;
    logic            rom_en;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_last;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    rom_burst_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    always @(posedge clk) rom_data <= rom_en ? mem[rom_addr] : '0;

    // Reference model: outstanding beats of the current burst, rotating priority, beat in flight.
    int m_left, m_addr, m_id, m_ptr;
    bit p_vld;
    int p_id, p_dat, p_last;
    int cyc;
    logic [3:0] hs;

    typedef struct { int id; int dat; int last; int cyc; } beat_t;
    int    grant_log [$];
    int    acc_log [$];
    beat_t rsp_log [$];
    logic [7:0] rq [4][$];

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (rst) rq[i].delete();
            req_valid[i] = (rq[i].size() > 0);
            req_addr[i*AW +: AW] = req_valid[i] ? rq[i][0][7:4] : 4'h0;
            req_len[i*AW +: AW]  = req_valid[i] ? rq[i][0][3:0] : 4'h0;
        end
    endtask

    // One clock cycle: model step and output checks at negedge, stimulus update after posedge.
    task automatic tick();
        int win;
        logic [3:0] exp_rdy;
        @(negedge clk);
        if (rst) begin
            m_left = 0; m_ptr = 0; p_vld = 0; hs = '0;
        end else begin
            checks++;
            if (rsp_valid !== p_vld) begin
                failures++;
                $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, p_vld);
            end
            if (p_vld && rsp_valid === 1'b1) begin
                checks++;
                if ({rsp_id, rsp_data, rsp_last} !== {2'(p_id), 8'(p_dat), 1'(p_last)}) begin
                    failures++;
                    $display("FAIL rsp_beat cyc=%0d got id=%0d data=%h last=%b exp id=%0d data=%h last=%0d",
                             cyc, rsp_id, rsp_data, rsp_last, p_id, p_dat, p_last);
                end
                rsp_log.push_back('{int'(rsp_id), int'(rsp_data), int'(rsp_last), cyc + 1});
            end
            checks++;
            if (busy !== ((m_left != 0) || p_vld)) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (m_left != 0) || p_vld);
            end
            exp_rdy = '0;
            win = -1;
            if (m_left == 0) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (win < 0 && req_valid[i]) win = i;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
            end
            hs = req_valid & req_ready;
            if (m_left != 0) begin
                checks++;
                if (rom_en !== 1'b1 || rom_addr !== 4'(m_addr)) begin
                    failures++;
                    $display("FAIL rom_issue cyc=%0d got en=%b addr=%0d exp en=1 addr=%0d",
                             cyc, rom_en, rom_addr, m_addr);
                end
                p_vld  = 1;
                p_id   = m_id;
                p_dat  = (m_addr * 17) % 256;
                p_last = (m_left == 1) ? 1 : 0;
                m_addr = (m_addr + 1) % 16;
                m_left--;
            end else begin
                checks++;
                if (rom_en !== 1'b0 || rom_addr !== 4'h0) begin
                    failures++;
                    $display("FAIL rom_idle cyc=%0d got en=%b addr=%0d exp en=0 addr=0",
                             cyc, rom_en, rom_addr);
                end
                p_vld = 0;
                if (win >= 0) begin
                    m_id   = win;
                    m_addr = int'(req_addr[win*AW +: AW]);
                    m_left = int'(req_len[win*AW +: AW]) + 1;
                    m_ptr  = (win + 1) % 4;
                    grant_log.push_back(win);
                    acc_log.push_back(cyc + 1);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 4; i++)
            if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive();
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 600 && !done; n++) begin
            tick();
            done = (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
                    rq[3].size() == 0 && m_left == 0 && !p_vld);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout got=busy exp=idle within 600 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        req_valid = 4'hF;
        #1;
        checks++;
        if ({req_ready, rom_en, rom_addr, rsp_valid, rsp_id, rsp_last, busy} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b en=%b addr=%0d vld=%b id=%0d last=%b busy=%b exp all 0",
                     req_ready, rom_en, rom_addr, rsp_valid, rsp_id, rsp_last, busy);
        end
        drive();
        rst = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single();
        int b0, g0;
        b0 = rsp_log.size(); g0 = grant_log.size();
        rq[0].push_back({4'd3, 4'd0});
        drive();
        wait_idle();
        checks++;
        if (grant_log.size() != g0 + 1 || rsp_log.size() != b0 + 1) begin
            failures++;
            $display("FAIL single_count got grants=%0d beats=%0d exp 1 and 1",
                     grant_log.size() - g0, rsp_log.size() - b0);
        end else begin
            checks++;
            if (grant_log[g0] != 0 || rsp_log[b0].dat != 'h33 || rsp_log[b0].id != 0 || rsp_log[b0].last != 1) begin
                failures++;
                $display("FAIL single_beat got grant=%0d data=%h id=%0d last=%0d exp 0 33 0 1",
                         grant_log[g0], rsp_log[b0].dat, rsp_log[b0].id, rsp_log[b0].last);
            end
            checks++;
            if (rsp_log[b0].cyc - acc_log[g0] != 2) begin
                failures++;
                $display("FAIL single_latency got=%0d exp=2", rsp_log[b0].cyc - acc_log[g0]);
            end
        end
    endtask

    task automatic test_wrap();
        int b0;
        int exp_dat [4];
        exp_dat = '{'hEE, 'hFF, 'h00, 'h11};
        b0 = rsp_log.size();
        rq[1].push_back({4'd14, 4'd3});
        drive();
        wait_idle();
        checks++;
        if (rsp_log.size() != b0 + 4) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=4", rsp_log.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rsp_log[b0+i].dat != exp_dat[i] || rsp_log[b0+i].id != 1 ||
                    rsp_log[b0+i].last != ((i == 3) ? 1 : 0)) begin
                    failures++;
                    $display("FAIL wrap_beat%0d got data=%h id=%0d last=%0d exp data=%h id=1 last=%0d",
                             i, rsp_log[b0+i].dat, rsp_log[b0+i].id, rsp_log[b0+i].last,
                             exp_dat[i], (i == 3) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_rr_all();
        int g0;
        int exp_g [6];
        exp_g = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        g0 = grant_log.size();
        for (int i = 0; i < 4; i++) rq[i].push_back({4'(i), 4'd0});
        rq[0].push_back({4'd4, 4'd0});
        rq[1].push_back({4'd5, 4'd0});
        drive();
        wait_idle();
        checks++;
        if (grant_log.size() != g0 + 6) begin
            failures++;
            $display("FAIL rr_count got=%0d exp=6", grant_log.size() - g0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (grant_log[g0+i] != exp_g[i]) begin
                    failures++;
                    $display("FAIL rr_order%0d got=%0d exp=%0d", i, grant_log[g0+i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_ptr3();
        int g0;
        int exp_g [3];
        exp_g = '{3, 0, 1};
        rq[2].push_back({4'd5, 4'd0});
        drive();
        wait_idle();
        g0 = grant_log.size();
        rq[0].push_back({4'd1, 4'd0});
        rq[1].push_back({4'd2, 4'd0});
        rq[3].push_back({4'd3, 4'd0});
        drive();
        wait_idle();
        checks++;
        if (grant_log.size() != g0 + 3) begin
            failures++;
            $display("FAIL ptr3_count got=%0d exp=3", grant_log.size() - g0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grant_log[g0+i] != exp_g[i]) begin
                    failures++;
                    $display("FAIL ptr3_order%0d got=%0d exp=%0d", i, grant_log[g0+i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int b0, g0;
        logic [4:0] en_seen, en_exp;
        int exp_dat [3];
        int exp_id [3];
        exp_dat = '{'h00, 'h11, 'h88};
        exp_id  = '{0, 0, 1};
        en_exp  = 5'b11010;
        b0 = rsp_log.size(); g0 = grant_log.size();
        rq[0].push_back({4'd0, 4'd1});
        rq[1].push_back({4'd8, 4'd0});
        drive();
        for (int n = 0; n < 20 && grant_log.size() == g0; n++) tick();
        for (int i = 4; i >= 0; i--) begin
            en_seen[i] = rom_en;
            tick();
        end
        checks++;
        if (en_seen !== en_exp) begin
            failures++;
            $display("FAIL b2b_rom_en got=%b exp=%b", en_seen, en_exp);
        end
        wait_idle();
        checks++;
        if (rsp_log.size() != b0 + 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", rsp_log.size() - b0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rsp_log[b0+i].dat != exp_dat[i] || rsp_log[b0+i].id != exp_id[i] ||
                    rsp_log[b0+i].last != ((i == 0) ? 0 : 1)) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got data=%h id=%0d last=%0d exp data=%h id=%0d last=%0d",
                             i, rsp_log[b0+i].dat, rsp_log[b0+i].id, rsp_log[b0+i].last,
                             exp_dat[i], exp_id[i], (i == 0) ? 0 : 1);
                end
            end
        end
    endtask

    task automatic test_random();
        int g0;
        logic [3:0] a, l;
        g0 = grant_log.size();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (rq[i].size() < 2 && $urandom_range(7) == 0) begin
                    a = 4'($urandom_range(15));
                    l = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
                    rq[i].push_back({a, l});
                end else if (rq[i].size() > 0 && $urandom_range(24) == 0) begin
                    void'(rq[i].pop_front());
                end
            end
            drive();
            tick();
        end
        wait_idle();
        checks++;
        if (grant_log.size() - g0 < 10) begin
            failures++;
            $display("FAIL random_activity got grants=%0d exp at least 10", grant_log.size() - g0);
        end
    endtask

    task automatic test_reset_mid();
        int g0, b0;
        g0 = grant_log.size();
        rq[1].push_back({4'd0, 4'd15});
        drive();
        for (int n = 0; n < 20 && grant_log.size() == g0; n++) tick();
        for (int n = 0; n < 5; n++) tick();
        checks++;
        if (rom_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midburst_active got en=%b busy=%b exp 1 1", rom_en, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rom_en, rom_addr, rsp_valid, busy, req_ready} !== 11'h0) begin
            failures++;
            $display("FAIL midburst_async got en=%b addr=%0d vld=%b busy=%b rdy=%b exp all 0",
                     rom_en, rom_addr, rsp_valid, busy, req_ready);
        end
        tick(); tick();
        rst = 1'b0;
        b0 = rsp_log.size();
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (rsp_log.size() != b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL postreset_quiet got beats=%0d busy=%b exp 0 0", rsp_log.size() - b0, busy);
        end
        g0 = grant_log.size();
        rq[1].push_back({4'd2, 4'd0});
        rq[3].push_back({4'd4, 4'd0});
        drive();
        wait_idle();
        checks++;
        if (grant_log.size() != g0 + 2 || grant_log[g0] != 1) begin
            failures++;
            $display("FAIL postreset_ptr got grants=%0d first=%0d exp 2 grants first=1",
                     grant_log.size() - g0, (grant_log.size() > g0) ? grant_log[g0] : -1);
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 8'(a * 17);
        req_valid = '0; req_addr = '0; req_len = '0; hs = '0;
        cyc = 0; m_left = 0; m_addr = 0; m_id = 0; m_ptr = 0;
        p_vld = 0; p_id = 0; p_dat = 0; p_last = 0;
        test_reset();
        test_single();
        test_wrap();
        test_rr_all();
        test_ptr3();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
